// File: rtl/mac_cam_table_pkg.sv
// mac_cam_table_pkg: shared types for the source-learning MAC table
package mac_cam_table_pkg;
    localparam int MAC_W = 48;

    typedef enum logic {S_IDLE, S_SCAN} state_type;

    typedef enum logic [1:0] {OP_LOOKUP, OP_LEARN, OP_DELETE} op_type;

    typedef struct packed {
        op_type           op;
        logic [MAC_W-1:0] key;
    } cmd_t;
endpackage

// File: rtl/mac_cam_table_if.sv
// mac_cam_table_if: command/response bus between the orchestrator and the MAC table
interface mac_cam_table_if
    import mac_cam_table_pkg::*;
#(
    parameter int PW = 1
);
    logic             cam_table_match_valid;
    logic [MAC_W-1:0] cam_table_write_data;
    logic             cam_table_write_data_valid;
    logic [PW-1:0]    cam_table_index;
    logic             cam_table_delete_key;
    logic [PW-1:0]    cam_table_match_index;
    logic             cam_table_match_enable;
    logic             cam_table_no_match;
    logic             busy;
    logic             command_overflow;
    logic [31:0]      entry_count;

    modport master (
        output cam_table_match_valid, cam_table_write_data, cam_table_write_data_valid,
               cam_table_index, cam_table_delete_key,
        input  cam_table_match_index, cam_table_match_enable, cam_table_no_match,
               busy, command_overflow, entry_count
    );

    modport slave (
        input  cam_table_match_valid, cam_table_write_data, cam_table_write_data_valid,
               cam_table_index, cam_table_delete_key,
        output cam_table_match_index, cam_table_match_enable, cam_table_no_match,
               busy, command_overflow, entry_count
    );
endinterface

// File: rtl/mac_cam_table.sv
// mac_cam_table: learning MAC table resolving lookup/learn/delete by a one-entry-per-cycle scan
module mac_cam_table
    import mac_cam_table_pkg::*;
#(
    parameter int NUMBER_OF_PORTS = 2,
    parameter int TABLE_DEPTH     = 32
) (
    input logic            clock,
    input logic            reset_n,
    mac_cam_table_if.slave bus
);
    localparam int PW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;
    localparam int IW = $clog2(TABLE_DEPTH);
    localparam int CW = IW + 1;

    state_type              state_q, state_d;
    logic [IW-1:0]          scan_q, scan_d, free_q, free_d, victim_q, victim_d;
    logic                   free_ok_q, free_ok_d;
    cmd_t                   op_q, op_d, hold_q, hold_d, stb_cmd;
    logic [PW-1:0]          idx_q, idx_d, hold_idx_q, hold_idx_d;
    logic                   hold_v_q, hold_v_d;
    logic [TABLE_DEPTH-1:0] valid_q, valid_d;
    logic [MAC_W-1:0]       key_mem [TABLE_DEPTH];
    logic [PW-1:0]          port_mem [TABLE_DEPTH];
    logic                   wr_en;
    logic [IW-1:0]          wr_addr;
    logic                   rsp_v_q, rsp_v_d, rsp_hit_q, rsp_hit_d;
    logic [PW-1:0]          rsp_port_q, rsp_port_d, match_idx_q, match_idx_d;
    logic                   match_en_q, match_en_d, no_match_q, no_match_d;
    logic                   ovf_q, ovf_d, busy_q, busy_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   any_stb, idle, hit, done, cur_free_ok;
    logic [IW-1:0]          cur_free;

    assign any_stb     = bus.cam_table_delete_key | bus.cam_table_write_data_valid | bus.cam_table_match_valid;
    assign idle        = state_q == S_IDLE;
    assign hit         = !idle && valid_q[scan_q] && key_mem[scan_q] == op_q.key;
    assign done        = !idle && (hit || scan_q == IW'(TABLE_DEPTH - 1));
    assign cur_free_ok = free_ok_q || !valid_q[scan_q];
    assign cur_free    = free_ok_q ? free_q : scan_q;

    always_comb begin
        stb_cmd.op  = bus.cam_table_delete_key ? OP_DELETE :
                      bus.cam_table_write_data_valid ? OP_LEARN : OP_LOOKUP;
        stb_cmd.key = bus.cam_table_write_data;
        state_d     = state_q;
        scan_d      = scan_q;
        free_d      = free_q;
        free_ok_d   = free_ok_q;
        victim_d    = victim_q;
        op_d        = op_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        hold_idx_d  = hold_idx_q;
        hold_v_d    = hold_v_q;
        valid_d     = valid_q;
        count_d     = count_q;
        wr_en       = 1'b0;
        wr_addr     = scan_q;
        rsp_v_d     = 1'b0;
        rsp_hit_d   = hit;
        rsp_port_d  = port_mem[scan_q];
        // lower-priority strobes in the same cycle are dropped
        ovf_d       = (bus.cam_table_delete_key & (bus.cam_table_write_data_valid | bus.cam_table_match_valid)) |
                      (bus.cam_table_write_data_valid & bus.cam_table_match_valid);
        if (!idle) begin
            scan_d = scan_q + IW'(1);
            if (!free_ok_q && !valid_q[scan_q]) begin
                free_ok_d = 1'b1;
                free_d    = scan_q;
            end
            if (done) begin
                state_d = S_IDLE;
                rsp_v_d = op_q.op == OP_LOOKUP;
                if (op_q.op == OP_LEARN) begin
                    wr_en   = 1'b1;
                    wr_addr = hit ? scan_q : cur_free_ok ? cur_free : victim_q;
                    if (!hit && cur_free_ok) begin
                        valid_d[wr_addr] = 1'b1;
                        count_d          = count_q + CW'(1);
                    end
                    if (!hit && !cur_free_ok) victim_d = victim_q + IW'(1);
                end
                if (op_q.op == OP_DELETE && hit) begin
                    valid_d[scan_q] = 1'b0;
                    count_d         = count_q - CW'(1);
                end
            end
        end
        if (idle && (hold_v_q || any_stb)) begin
            op_d      = hold_v_q ? hold_q : stb_cmd;
            idx_d     = hold_v_q ? hold_idx_q : bus.cam_table_index;
            hold_v_d  = 1'b0;
            state_d   = S_SCAN;
            scan_d    = '0;
            free_ok_d = 1'b0;
        end
        // the holding register is freed in the same cycle it dispatches
        if (any_stb && !(idle && !hold_v_q)) begin
            if (!hold_v_q || idle) begin
                hold_d     = stb_cmd;
                hold_idx_d = bus.cam_table_index;
                hold_v_d   = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        match_en_d  = rsp_v_q && rsp_hit_q;
        no_match_d  = rsp_v_q && !rsp_hit_q;
        match_idx_d = (rsp_v_q && rsp_hit_q) ? rsp_port_q : '0;
        busy_d      = (state_d != S_IDLE) || hold_v_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            scan_q      <= '0;
            free_q      <= '0;
            free_ok_q   <= 1'b0;
            victim_q    <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_idx_q  <= '0;
            hold_v_q    <= 1'b0;
            valid_q     <= '0;
            count_q     <= '0;
            rsp_v_q     <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_port_q  <= '0;
            match_en_q  <= 1'b0;
            no_match_q  <= 1'b0;
            match_idx_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_q      <= scan_d;
            free_q      <= free_d;
            free_ok_q   <= free_ok_d;
            victim_q    <= victim_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            hold_idx_q  <= hold_idx_d;
            hold_v_q    <= hold_v_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            rsp_v_q     <= rsp_v_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_port_q  <= rsp_port_d;
            match_en_q  <= match_en_d;
            no_match_q  <= no_match_d;
            match_idx_q <= match_idx_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            key_mem[wr_addr]  <= op_q.key;
            port_mem[wr_addr] <= idx_q;
        end
    end

    assign bus.cam_table_match_index  = match_idx_q;
    assign bus.cam_table_match_enable = match_en_q;
    assign bus.cam_table_no_match     = no_match_q;
    assign bus.busy                   = busy_q;
    assign bus.command_overflow       = ovf_q;
    assign bus.entry_count            = 32'(count_q);
endmodule
